// File: rtl/c_result_streamer.sv
// ---------------------------------------------------------------------------
// c_result_streamer
//
// Output-side AXI-Stream master for the systolic array result path. Captures
// the whole N x N result matrix C in a single cycle and then streams it to a
// downstream sink, one element per beat, in row-major order.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst_n       asynchronous active-low reset
//   arr_C_valid   array result valid (pulse or level)
//   arr_C_data    result matrix, element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
//   o_cap_ready   a capture is accepted this cycle
//   m_axis_data   current element (driven from the matrix register only)
//   m_axis_valid  AXIS valid
//   m_axis_ready  AXIS ready from the sink
//   m_axis_last   high on element N*N-1
//   o_done        one-cycle pulse after the last beat handshakes
//   o_overrun     sticky, a capture arrived while o_cap_ready was low
//   dbg_state     FSM state (0 = IDLE, 1 = SEND) for observation
//
// Handshake: a beat transfers on a rising edge where m_axis_valid and
// m_axis_ready are both high. Once valid is raised, data, last and valid hold
// steady until that edge; valid is never withdrawn early (only reset drops it).
// ---------------------------------------------------------------------------
module c_result_streamer #(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       arr_C_valid,
    input  logic [N*N*DATA_W-1:0]      arr_C_data,
    output logic                       o_cap_ready,
    output logic [DATA_W-1:0]          m_axis_data,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic                       m_axis_last,
    output logic                       o_done,
    output logic                       o_overrun,
    output logic                       dbg_state
);

    localparam int NN    = N * N;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NN-1:0][DATA_W-1:0]     mat_q;
    logic                          done_q, done_d;
    logic                          overrun_q;
    logic                          load;
    logic                          is_last;
    logic                          beat;

    assign is_last = (state_q == S_SEND) && (idx_q == LAST_IDX);
    assign beat    = (state_q == S_SEND) && m_axis_ready;

    // A new matrix may be taken while the final beat of the previous one is
    // handshaking, so back-to-back results stream without a bubble.
    assign o_cap_ready = (state_q == S_IDLE) || (is_last && m_axis_ready);

    assign m_axis_valid = (state_q == S_SEND);
    assign m_axis_last  = is_last;
    assign m_axis_data  = mat_q[idx_q];
    assign o_done       = done_q;
    assign o_overrun    = overrun_q;
    assign dbg_state    = (state_q == S_SEND);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arr_C_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (beat) begin
                    if (is_last) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (arr_C_valid) begin
                            load    = 1'b1;
                            state_d = S_SEND;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            mat_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (load) begin
                mat_q <= arr_C_data;
            end
            // A capture request that cannot be honoured is dropped; the
            // matrix being streamed is left untouched.
            if (arr_C_valid && !o_cap_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule
